// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t     : responder FSM state encoding (IDLE / WAIT / RESP)
//   CNT_W       : width of the wait-state counter
//   ADDR_W, DATA_W, BE_W, OFS_W : bus widths and byte-offset width
//   addr_error  : flags a misaligned or out-of-range byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int OFS_W  = 2;

  // A request is in error when it is not word aligned or its word index
  // falls past the end of the array.
  function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
    logic [ADDR_W-1:0] widx;
    widx = {{OFS_W{1'b0}}, addr[ADDR_W-1:OFS_W]};
    return (addr[OFS_W-1:0] != {OFS_W{1'b0}}) || (widx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage for the data-memory responder.
//   clk   : clock, writes happen on the rising edge
//   we    : write strobe
//   idx   : word index used for both the write and the read
//   wdata : write data
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   rdata : combinational read of the word at idx
// Contents are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

  // Byte-enabled synchronous write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed number of wait states.
//   CLK        : system clock
//   Reset_L    : asynchronous active-low reset
//   req_*      : request channel (valid/ready, write, byte address, data, byte enables)
//   rsp_*      : response channel (valid/ready, load data, error flag)
// One request is in flight at a time. The store is committed and the load
// data captured on the edge that enters RESP; the response is then held until
// the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_byteen,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int               IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                accept_s, commit_s, err_s, we_s;
  logic                lat_write_r;
  logic [ADDR_W-1:0]   lat_addr_r;
  logic [DATA_W-1:0]   lat_wdata_r;
  logic [BE_W-1:0]     lat_be_r;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   arr_rdata_s;
  logic                req_ready_r, rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0]   rsp_rdata_r;

  assign err_s = addr_error(lat_addr_r, DEPTH_WORDS);
  assign idx_s = lat_addr_r[IDX_W+OFS_W-1:OFS_W];
  assign we_s  = commit_s && lat_write_r && !err_s;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (CLK),
    .we    (we_s),
    .idx   (idx_s),
    .wdata (lat_wdata_r),
    .be    (lat_be_r),
    .rdata (arr_rdata_s)
  );

  // Next-state logic. The accept cycle always passes through WAIT, which
  // counts the latched wait states down to zero, so the response appears
  // WAIT_CYCLES+1 edges after acceptance (one edge even with zero wait states).
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s    = 1'b1;
          cnt_nxt_s   = WAIT_LD;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          commit_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request latch, loaded only on acceptance.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      lat_write_r <= 1'b0;
      lat_addr_r  <= {ADDR_W{1'b0}};
      lat_wdata_r <= {DATA_W{1'b0}};
      lat_be_r    <= {BE_W{1'b0}};
    end else if (accept_s) begin
      lat_write_r <= req_write;
      lat_addr_r  <= req_addr;
      lat_wdata_r <= req_wdata;
      lat_be_r    <= req_byteen;
    end
  end

  // Registered handshake outputs and response payload. The ready flag is
  // derived from the next state so it is low during reset and rises on the
  // first edge after release or after a response handshake.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (commit_s) begin
        rsp_rdata_r <= (lat_write_r || err_s) ? {DATA_W{1'b0}} : arr_rdata_s;
        rsp_err_r   <= err_s;
      end else if ((state_r == ST_RESP) && (state_nxt_s == ST_IDLE)) begin
        rsp_rdata_r <= {DATA_W{1'b0}};
        rsp_err_r   <= 1'b0;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states, 256 words)
// driven by directed transactions and then randomized traffic, each checked
// every cycle against a transaction-level model of the memory.
module tb_dmem_responder;

  logic             CLK = 1'b0;
  logic [1:0]       rst_n;
  logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_byteen;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_w2 (
    .CLK(CLK), .Reset_L(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_byteen(req_byteen[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(CLK), .Reset_L(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_byteen(req_byteen[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: memory image with per-byte "written" flags, and
  // for each instance whether a transaction is outstanding, how many edges
  // have passed since it was accepted, and the response it must produce.
  bit [31:0] mem [2][256];
  bit [3:0]  kn  [2][256];
  bit        m_started[2], m_busy[2], m_rv[2], m_err[2], m_rdknown[2], m_acc[2];
  int        m_age[2];
  bit [31:0] m_rdata[2];
  bit        p_write[2];
  bit [31:0] p_addr[2], p_wdata[2];
  bit [3:0]  p_be[2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_update(input int k);
    bit e;
    int idx;
    m_acc[k] = 1'b0;
    if (!rst_n[k]) begin
      m_started[k] = 1'b0;
      m_busy[k]    = 1'b0;
      m_rv[k]      = 1'b0;
      return;
    end
    if (!m_started[k]) begin
      m_started[k] = 1'b1;
    end else if (!m_busy[k]) begin
      if (req_valid[k]) begin
        m_acc[k]   = 1'b1;
        m_busy[k]  = 1'b1;
        m_age[k]   = 0;
        p_write[k] = req_write[k];
        p_addr[k]  = req_addr[k];
        p_wdata[k] = req_wdata[k];
        p_be[k]    = req_byteen[k];
      end
    end else if (m_rv[k]) begin
      if (rsp_ready[k]) begin
        m_busy[k] = 1'b0;
        m_rv[k]   = 1'b0;
      end
    end else begin
      m_age[k]++;
      if (m_age[k] == wait_of(k) + 1) begin
        e   = (p_addr[k] % 4 != 0) || ((p_addr[k] / 4) >= 256);
        idx = int'(p_addr[k] / 4);
        m_err[k] = e;
        if (e || p_write[k]) begin
          m_rdata[k]   = 32'd0;
          m_rdknown[k] = 1'b1;
        end else begin
          m_rdata[k]   = mem[k][idx];
          m_rdknown[k] = (kn[k][idx] == 4'hF);
        end
        if (!e && p_write[k]) begin
          for (int i = 0; i < 4; i++) begin
            if (p_be[k][i]) begin
              mem[k][idx][8*i +: 8] = p_wdata[k][8*i +: 8];
              kn[k][idx][i] = 1'b1;
            end
          end
        end
        m_rv[k] = 1'b1;
      end
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("req_ready[%0d]", k), {31'd0, req_ready[k]},
        {31'd0, (m_started[k] && !m_busy[k])});
    chk($sformatf("rsp_valid[%0d]", k), {31'd0, rsp_valid[k]}, {31'd0, m_rv[k]});
    if (m_rv[k]) begin
      chk($sformatf("rsp_err[%0d]", k), {31'd0, rsp_err[k]}, {31'd0, m_err[k]});
      if (m_rdknown[k]) chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], m_rdata[k]);
    end
    if (!rst_n[k]) begin
      chk($sformatf("reset_rdata[%0d]", k), rsp_rdata[k], 32'd0);
      chk($sformatf("reset_err[%0d]", k), {31'd0, rsp_err[k]}, 32'd0);
    end
  endtask

  // One clock: advance the model on the rising edge, check on the falling edge.
  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < 2; k++) model_update(k);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic txn(input int k, input bit wr, input logic [31:0] addr, wdata,
                     input logic [3:0] be, input int stall,
                     output logic [31:0] rd, output logic e, output int lat);
    bit got;
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
    req_wdata[k] = wdata; req_byteen[k] = be;
    rsp_ready[k] = (stall == 0);
    got = 1'b0;
    for (int g = 0; g < 40 && !got; g++) begin
      tick();
      if (m_acc[k]) got = 1'b1;
    end
    req_valid[k] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout[%0d]: request not accepted in 40 cycles", k);
    end
    lat = 0; got = 1'b0; rd = 32'd0; e = 1'b0;
    for (int g = 0; g < 40 && !got; g++) begin
      tick();
      lat++;
      if (rsp_valid[k]) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_timeout[%0d]: no rsp_valid in 40 cycles", k);
    end
    rd = rsp_rdata[k];
    e  = rsp_err[k];
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", {31'd0, rsp_valid[k]}, 32'd1);
      chk("stall_rdata", rsp_rdata[k], rd);
      chk("stall_ready", {31'd0, req_ready[k]}, 32'd0);
    end
    rsp_ready[k] = 1'b1;
    tick();
    chk("post_hs_ready", {31'd0, req_ready[k]}, 32'd1);
    chk("post_hs_valid", {31'd0, rsp_valid[k]}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  bit          got;
  int          r;

  initial begin
    rst_n = 2'b00; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_byteen = '0; rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 0; m_busy[k] = 0; m_rv[k] = 0; m_acc[k] = 0;
    end
    tick(); tick();
    chk("reset_req_ready", {31'd0, req_ready[0]}, 32'd0);
    rst_n = 2'b11;
    tick();
    chk("release_req_ready", {31'd0, req_ready[0]}, 32'd1);

    // Directed, 2 wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat);
    chk("store_lat", lat, 32'd3);
    chk("store_err", {31'd0, e}, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("load_lat", lat, 32'd3);
    chk("load_data", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, rd, e, lat);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, e, lat);
    chk("partial_data", rd, 32'hDEADAAEF);
    txn(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, rd, e, lat);
    chk("misalign_err", {31'd0, e}, 32'd1);
    chk("misalign_data", rd, 32'd0);
    txn(0, 1'b1, 32'h400, 32'h12345678, 4'hF, 0, rd, e, lat);
    chk("range_err", {31'd0, e}, 32'd1);
    txn(0, 1'b1, 32'h14, 32'h0BADF00D, 4'h0, 0, rd, e, lat);
    chk("noop_store_err", {31'd0, e}, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, e, lat);
    chk("stall_load_data", rd, 32'hDEADAAEF);

    // Directed, 0 wait states, back to back.
    txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, e, lat);
    chk("w0_store_lat", lat, 32'd1);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat);
    chk("w0_load_lat", lat, 32'd1);
    chk("w0_load_data", rd, 32'hCAFEF00D);

    // Reset in the middle of a store's wait states abandons the store.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h11223344; req_byteen[0] = 4'hF;
    got = 1'b0;
    for (int g = 0; g < 40 && !got; g++) begin
      tick();
      if (m_acc[0]) got = 1'b1;
    end
    chk("wait_reset_accept", {31'd0, got}, 32'd1);
    req_valid[0] = 1'b0;
    rst_n[0] = 1'b0;
    tick(); tick();
    rst_n[0] = 1'b1;
    tick();
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("abandoned_store", rd, 32'hDEADAAEF);

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rst_n[k]) begin
          rst_n[k] = 1'b1;
        end else if ($urandom_range(0, 599) == 0) begin
          rst_n[k] = 1'b0;
          req_valid[k] = 1'b0;
        end
        if (rst_n[k] && !(req_valid[k] && !m_acc[k])) begin
          if ($urandom_range(0, 2) != 0) begin
            r = int'($urandom_range(0, 15));
            if (r < 12)       req_addr[k] = 32'($urandom_range(0, 7)) << 2;
            else if (r < 14)  req_addr[k] = (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(1, 3));
            else if (r == 14) req_addr[k] = ($urandom_range(0, 1) == 0) ? 32'h3FC : 32'h400;
            else              req_addr[k] = $urandom;
            req_valid[k]  = 1'b1;
            req_write[k]  = $urandom_range(0, 1) == 1;
            req_wdata[k]  = $urandom;
            req_byteen[k] = 4'($urandom_range(0, 15));
          end else begin
            req_valid[k] = 1'b0;
          end
        end
        rsp_ready[k] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
